uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
// - Byte buffer between the uart_drive receive user port and its transmit user port in the echo path.
// - Accepts fire-and-forget bytes (data+valid, no backpressure) and presents them first-word-fall-through
//   on a valid/ready interface that drives i_user_tx_data / i_user_tx_valid / o_user_tx_ready.
// - Replaces the IP FIFO plus the glue read logic in the top level, and adds overflow reporting.
// PARAMETERS
// - P_DATA_WIDTH   8   byte width, matches P_UART_DATA_WIDTH of uart_drive
// - P_ADDR_WIDTH   4   RAM depth = 2**P_ADDR_WIDTH entries (16); total capacity = depth + 1 output register
// PORTS
// - i_clk          in   1              single clock (uart_drive o_user_clk)
// - i_rst          in   1              synchronous, active-high reset (uart_drive o_user_rst)
// - i_rx_data      in   P_DATA_WIDTH   byte from receiver
// - i_rx_valid     in   1              one-cycle write strobe
// - o_tx_data      out  P_DATA_WIDTH   head byte, stable while o_tx_valid=1 and i_tx_ready=0
// - o_tx_valid     out  1              head byte present
// - i_tx_ready     in   1              transmitter accepts; transfer = o_tx_valid & i_tx_ready
// - o_full         out  1              RAM holds 2**P_ADDR_WIDTH entries
// - o_empty        out  1              RAM empty AND output register empty
// - o_overflow     out  1              sticky: a write was dropped
// - o_level        out  P_ADDR_WIDTH+2 entries held, RAM + output register (only with UART_TX_FIFO_LEVEL_EN)
// BEHAVIOUR
// - Reset (sync, i_rst=1 at posedge): wr_ptr=rd_ptr=0, RAM count=0, o_tx_valid=0, o_tx_data=0,
//   o_full=0, o_empty=1, o_overflow=0, o_level=0. A reset mid-transfer discards all contents; RAM is not cleared.
// - Pointers are P_ADDR_WIDTH+1 bits (wrap bit). full = MSBs differ & lower bits equal; RAM empty = pointers equal.
//   Both pointers wrap naturally modulo 2**(P_ADDR_WIDTH+1).
// - Write: i_rx_valid=1 & !o_full -> RAM[wr_ptr] <= i_rx_data, wr_ptr++ at the same edge.
//   i_rx_valid=1 & o_full -> byte dropped, pointers unchanged, o_overflow <= 1 (held until reset).
//   o_full is the registered state: a simultaneous pop does not rescue a write while full.
// - Output register load: at an edge where RAM is non-empty and (o_tx_valid=0 or the transfer fires):
//   o_tx_data <= RAM[rd_ptr], rd_ptr++, o_tx_valid <= 1.
// - Output register release: transfer fires and RAM is empty -> o_tx_valid <= 0; o_tx_data holds its last value.
// - Latency: a byte written into an empty FIFO at edge N is in RAM after N and on o_tx_data with o_tx_valid=1
//   after edge N+1 (2 cycles). No RAM-to-output bypass path.
// - Throughput: 1 byte/cycle in each direction. Back-to-back transfers with i_tx_ready held high never insert bubbles
//   while the RAM is non-empty.
// - Simultaneous write and load in the same cycle: both occur; RAM count is unchanged.
// - o_tx_valid never drops without a transfer. o_tx_data never changes while o_tx_valid=1 and i_tx_ready=0.
// - o_full, o_empty and o_level are registered, updated at the same edge as the pointers. No combinational input->output path.
// - Level = RAM count + o_tx_valid, range 0 .. 2**P_ADDR_WIDTH+1.
// CONFIGURATION
// - UART_TX_FIFO_LEVEL_EN defined: port o_level exists and is driven as above.
// - UART_TX_FIFO_LEVEL_EN undefined: port o_level and its counter are absent. All other behaviour is identical.
// TESTING
// - Reset, then 1 write of 0xA5 at edge N -> o_tx_valid=1 and o_tx_data=0xA5 after N+1; o_empty=0; o_level=1.
// - i_tx_ready=0; write 0x00..0x10 (17 bytes) back-to-back -> o_full=1 after byte 17, o_level=17, o_overflow=0;
//   18th byte 0x11 -> o_overflow=1.
// - Continue the previous case with i_tx_ready=1 -> bytes 0x00..0x10 are transferred on 17 consecutive cycles, in order.
//   0x11 never appears. o_empty=1 and o_tx_valid=0 after the last transfer.
// - Random i_tx_ready with a continuous write/read stream of 300 bytes, exercising pointer wrap -> output sequence equals
//   input sequence; o_tx_data is stable whenever valid&!ready.
// - Fill with 5 bytes, assert i_rst for one cycle while i_tx_ready=1 -> outputs return to reset values at the next edge.
//   A write of 0x3C after reset appears alone, 2 cycles later.
// - With o_full=1, i_rx_valid=1 and transfer in the same cycle -> the write is dropped, o_overflow=1, level decreases by 1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART echo path: fire-and-forget writes, first-word-fall-through valid/ready read side.
// Optional occupancy output o_level is built only when UART_TX_FIFO_LEVEL_EN is defined.
module uart_tx_fifo #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [P_DATA_WIDTH-1:0] i_rx_data,
  input  logic                    i_rx_valid,
  output logic [P_DATA_WIDTH-1:0] o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_full,
  output logic                    o_empty,
  output logic                    o_overflow
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [P_ADDR_WIDTH+1:0] o_level
`endif
);

  localparam int DEPTH = 2 ** P_ADDR_WIDTH;

  logic [P_DATA_WIDTH-1:0] mem [DEPTH];

  logic [P_ADDR_WIDTH:0] wr_ptr;
  logic [P_ADDR_WIDTH:0] rd_ptr;
  logic [P_ADDR_WIDTH:0] wr_ptr_nxt;
  logic [P_ADDR_WIDTH:0] rd_ptr_nxt;
  logic                  wr_en;
  logic                  xfer;
  logic                  ram_ne;
  logic                  load;
  logic                  vld_nxt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic logic ptr_full(input logic [P_ADDR_WIDTH:0] w, input logic [P_ADDR_WIDTH:0] r);
    return (w[P_ADDR_WIDTH] != r[P_ADDR_WIDTH]) && (w[P_ADDR_WIDTH-1:0] == r[P_ADDR_WIDTH-1:0]);
  endfunction

  function automatic logic [P_ADDR_WIDTH:0] ram_count(input logic [P_ADDR_WIDTH:0] w,
                                                      input logic [P_ADDR_WIDTH:0] r);
    return w - r;
  endfunction

  always_comb begin
    wr_en      = i_rx_valid & ~o_full;
    xfer       = o_tx_valid & i_tx_ready;
    ram_ne     = (wr_ptr != rd_ptr);
    load       = ram_ne & (~o_tx_valid | xfer);
    vld_nxt    = load | (o_tx_valid & ~xfer);
    wr_ptr_nxt = wr_ptr + {{P_ADDR_WIDTH{1'b0}}, wr_en};
    rd_ptr_nxt = rd_ptr + {{P_ADDR_WIDTH{1'b0}}, load};
  end

  // Storage is never reset; the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr[P_ADDR_WIDTH-1:0]] <= i_rx_data;
    end
  end

  // Output stage: head byte register, refilled from RAM only (no bypass), so a write reaches o_tx_data two edges later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= '0;
      o_full     <= 1'b0;
      o_empty    <= 1'b1;
      o_overflow <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      o_tx_valid <= vld_nxt;
      if (load) begin
        o_tx_data <= mem[rd_ptr[P_ADDR_WIDTH-1:0]];
      end
      o_full  <= ptr_full(wr_ptr_nxt, rd_ptr_nxt);
      o_empty <= (wr_ptr_nxt == rd_ptr_nxt) & ~vld_nxt;
      if (i_rx_valid & o_full) begin
        o_overflow <= 1'b1;
      end
    end
  end

`ifdef UART_TX_FIFO_LEVEL_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_level <= '0;
    end else begin
      o_level <= {1'b0, ram_count(wr_ptr_nxt, rd_ptr_nxt)} + {{(P_ADDR_WIDTH+1){1'b0}}, vld_nxt};
    end
  end
`endif

endmodule
